// File: rtl/csr_cpuif_arbiter.sv
// Two-requester round-robin arbiter in front of a single CSR cpuif port.
// Ports: clk/rst; per requester mN_req/_is_wr/_addr/_wr_data/_wr_biten in,
//   mN_stall/_rsp_valid/_rsp_err/_rd_data out; cpuif_* request out,
//   cpuif_rd_ack/_rd_err/_rd_data/_wr_ack/_wr_err completion in.
module csr_cpuif_arbiter #(
  parameter int ADDR_WIDTH     = 3,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  m0_req,
  input  logic                  m0_req_is_wr,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wr_data,
  input  logic [DATA_WIDTH-1:0] m0_wr_biten,
  output logic                  m0_stall,
  output logic                  m0_rsp_valid,
  output logic                  m0_rsp_err,
  output logic [DATA_WIDTH-1:0] m0_rd_data,

  input  logic                  m1_req,
  input  logic                  m1_req_is_wr,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wr_data,
  input  logic [DATA_WIDTH-1:0] m1_wr_biten,
  output logic                  m1_stall,
  output logic                  m1_rsp_valid,
  output logic                  m1_rsp_err,
  output logic [DATA_WIDTH-1:0] m1_rd_data,

  output logic                  cpuif_req,
  output logic                  cpuif_req_is_wr,
  output logic [ADDR_WIDTH-1:0] cpuif_addr,
  output logic [DATA_WIDTH-1:0] cpuif_wr_data,
  output logic [DATA_WIDTH-1:0] cpuif_wr_biten,

  input  logic                  cpuif_rd_ack,
  input  logic                  cpuif_rd_err,
  input  logic [DATA_WIDTH-1:0] cpuif_rd_data,
  input  logic                  cpuif_wr_ack,
  input  logic                  cpuif_wr_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  logic                  last_q, last_d;
  logic                  gnt_q, gnt_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] biten_q, biten_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  grant;
  logic                  done;
  logic [7:0]            cnt_inc;
  logic                  tmo;

  // On a tie, the requester not served last time wins.
  assign grant = (m0_req && m1_req) ? ~last_q : m1_req;

  // Only the ack matching the latched access type completes it.
  assign done = wr_q ? cpuif_wr_ack : cpuif_rd_ack;

  // Timeout fires on the cycle the counter steps onto its last value.
  assign cnt_inc = cnt_q + 8'd1;
  assign tmo     = (cnt_inc == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      biten_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      biten_q <= biten_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    biten_d = biten_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          gnt_d   = grant;
          last_d  = grant;
          cnt_d   = '0;
          state_d = S_ISSUE;
          if (grant) begin
            wr_d    = m1_req_is_wr;
            addr_d  = m1_addr;
            wdata_d = m1_wr_data;
            biten_d = m1_wr_biten;
          end else begin
            wr_d    = m0_req_is_wr;
            addr_d  = m0_addr;
            wdata_d = m0_wr_data;
            biten_d = m0_wr_biten;
          end
        end
      end

      S_ISSUE, S_WAIT: begin
        cnt_d = cnt_inc;
        if (done) begin
          err_d   = wr_q ? cpuif_wr_err : cpuif_rd_err;
          rdata_d = wr_q ? '0 : cpuif_rd_data;
          state_d = S_RESP;
        end else if (tmo) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign m0_stall = m0_req && !(state_q == S_IDLE && !grant);
  assign m1_stall = m1_req && !(state_q == S_IDLE && grant);

  assign cpuif_req       = (state_q == S_ISSUE);
  assign cpuif_req_is_wr = wr_q;
  assign cpuif_addr      = addr_q;
  assign cpuif_wr_data   = wdata_q;
  assign cpuif_wr_biten  = biten_q;

  assign m0_rsp_valid = (state_q == S_RESP) && !gnt_q;
  assign m1_rsp_valid = (state_q == S_RESP) && gnt_q;

  assign m0_rsp_err = m0_rsp_valid && err_q;
  assign m1_rsp_err = m1_rsp_valid && err_q;
  assign m0_rd_data = m0_rsp_valid ? rdata_q : '0;
  assign m1_rd_data = m1_rsp_valid ? rdata_q : '0;

endmodule

// File: tb/tb_csr_cpuif_arbiter.sv
// Bench for csr_cpuif_arbiter: vector table plus hand sequences,
// responses checked against a scoreboard queue.
module tb_csr_cpuif_arbiter;

  localparam int AW = 3;
  localparam int DW = 32;
  localparam int TO_MAIN = 16;
  localparam int TO_SMALL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          m0_req, m0_req_is_wr, m1_req, m1_req_is_wr;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wr_data, m0_wr_biten, m1_wr_data, m1_wr_biten;
  logic          m0_stall, m0_rsp_valid, m0_rsp_err;
  logic          m1_stall, m1_rsp_valid, m1_rsp_err;
  logic [DW-1:0] m0_rd_data, m1_rd_data;
  logic          cpuif_req, cpuif_req_is_wr;
  logic [AW-1:0] cpuif_addr;
  logic [DW-1:0] cpuif_wr_data, cpuif_wr_biten;
  logic          rd_ack, rd_err, wr_ack, wr_err;
  logic [DW-1:0] rd_data;

  logic          t_req;
  logic          t_stall0, t_rv0, t_re0, t_stall1, t_rv1, t_re1;
  logic [DW-1:0] t_rd0, t_rd1;
  logic          t_creq, t_cwr;
  logic [AW-1:0] t_caddr;
  logic [DW-1:0] t_cwd, t_cbe;

  csr_cpuif_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO_MAIN)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_req_is_wr(m0_req_is_wr), .m0_addr(m0_addr),
    .m0_wr_data(m0_wr_data), .m0_wr_biten(m0_wr_biten),
    .m0_stall(m0_stall), .m0_rsp_valid(m0_rsp_valid),
    .m0_rsp_err(m0_rsp_err), .m0_rd_data(m0_rd_data),
    .m1_req(m1_req), .m1_req_is_wr(m1_req_is_wr), .m1_addr(m1_addr),
    .m1_wr_data(m1_wr_data), .m1_wr_biten(m1_wr_biten),
    .m1_stall(m1_stall), .m1_rsp_valid(m1_rsp_valid),
    .m1_rsp_err(m1_rsp_err), .m1_rd_data(m1_rd_data),
    .cpuif_req(cpuif_req), .cpuif_req_is_wr(cpuif_req_is_wr),
    .cpuif_addr(cpuif_addr), .cpuif_wr_data(cpuif_wr_data),
    .cpuif_wr_biten(cpuif_wr_biten),
    .cpuif_rd_ack(rd_ack), .cpuif_rd_err(rd_err), .cpuif_rd_data(rd_data),
    .cpuif_wr_ack(wr_ack), .cpuif_wr_err(wr_err)
  );

  csr_cpuif_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO_SMALL)
  ) u_to (
    .clk(clk), .rst(rst),
    .m0_req(t_req), .m0_req_is_wr(m0_req_is_wr), .m0_addr(m0_addr),
    .m0_wr_data(m0_wr_data), .m0_wr_biten(m0_wr_biten),
    .m0_stall(t_stall0), .m0_rsp_valid(t_rv0),
    .m0_rsp_err(t_re0), .m0_rd_data(t_rd0),
    .m1_req(1'b0), .m1_req_is_wr(m1_req_is_wr), .m1_addr(m1_addr),
    .m1_wr_data(m1_wr_data), .m1_wr_biten(m1_wr_biten),
    .m1_stall(t_stall1), .m1_rsp_valid(t_rv1),
    .m1_rsp_err(t_re1), .m1_rd_data(t_rd1),
    .cpuif_req(t_creq), .cpuif_req_is_wr(t_cwr),
    .cpuif_addr(t_caddr), .cpuif_wr_data(t_cwd),
    .cpuif_wr_biten(t_cbe),
    .cpuif_rd_ack(rd_ack), .cpuif_rd_err(rd_err), .cpuif_rd_data(rd_data),
    .cpuif_wr_ack(wr_ack), .cpuif_wr_err(wr_err)
  );

  typedef struct {
    bit          mst;
    bit          wr;
    bit [AW-1:0] addr;
    bit [DW-1:0] wdata;
    bit [DW-1:0] biten;
    bit [DW-1:0] rdata;
    int          d;
    bit          err;
    bit          wrong;
  } vec_t;

  typedef struct {
    bit          mst;
    bit          err;
    bit [DW-1:0] data;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ack();
    rd_ack = 1'b0;
    rd_err = 1'b0;
    rd_data = '0;
    wr_ack = 1'b0;
    wr_err = 1'b0;
  endtask

  function automatic bit tmo_of(int d);
    return (d + 1) > (TO_MAIN - 1);
  endfunction

  function automatic int lat_of(int d);
    return tmo_of(d) ? TO_MAIN : d + 2;
  endfunction

  function automatic logic stall_of(bit m);
    return m ? m1_stall : m0_stall;
  endfunction

  function automatic logic req_of(bit m);
    return m ? m1_req : m0_req;
  endfunction

  function automatic logic rv_of(bit m);
    return m ? m1_rsp_valid : m0_rsp_valid;
  endfunction

  task automatic set_req(bit m, bit on, vec_t v);
    if (m) begin
      m1_req = on; m1_req_is_wr = v.wr; m1_addr = v.addr;
      m1_wr_data = v.wdata; m1_wr_biten = v.biten;
    end else begin
      m0_req = on; m0_req_is_wr = v.wr; m0_addr = v.addr;
      m0_wr_data = v.wdata; m0_wr_biten = v.biten;
    end
  endtask

  task automatic push_exp(vec_t v);
    exp_t e;
    e.mst = v.mst;
    e.err = tmo_of(v.d) ? 1'b1 : v.err;
    e.data = (tmo_of(v.d) || v.wr) ? '0 : v.rdata;
    sb.push_back(e);
  endtask

  // Runs from the accept edge until the response cycle, then one more
  // edge so the DUT is back in IDLE on return.
  task automatic finish_txn(vec_t v);
    int k;
    bit seen;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      k++;
      cyc();
      clr_ack();
      if (k == 1) begin
        chk("issue_req", 32'(cpuif_req), 32'd1);
        chk("issue_wr", 32'(cpuif_req_is_wr), 32'(v.wr));
        chk("issue_addr", 32'(cpuif_addr), 32'(v.addr));
        chk("issue_wdata", cpuif_wr_data, v.wdata);
        chk("issue_biten", cpuif_wr_biten, v.biten);
        set_req(v.mst, 1'b0, v);
      end else begin
        chk("req_one_cycle", 32'(cpuif_req), 32'd0);
      end
      chk("other_stall", 32'(stall_of(~v.mst)), 32'(req_of(~v.mst)));
      if (rv_of(v.mst)) begin
        seen = 1'b1;
        chk("latency", 32'(k), 32'(lat_of(v.d)));
        chk("hold_addr", 32'(cpuif_addr), 32'(v.addr));
      end
      if (k == 1 + v.d) begin
        if (v.wr) begin
          wr_ack = 1'b1; wr_err = v.err;
        end else begin
          rd_ack = 1'b1; rd_err = v.err; rd_data = v.rdata;
        end
      end
      if (v.wrong && k == 1) begin
        if (v.wr) begin
          rd_ack = 1'b1; rd_err = 1'b1; rd_data = 32'hBAD0BAD0;
        end else begin
          wr_ack = 1'b1; wr_err = 1'b1;
        end
      end
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL rsp_timeout: got none expected response");
    end
    cyc();
    clr_ack();
  endtask

  task automatic run_vec(vec_t v);
    set_req(v.mst, 1'b1, v);
    #1;
    chk("accept_stall", 32'(stall_of(v.mst)), 32'd0);
    push_exp(v);
    finish_txn(v);
  endtask

  always @(negedge clk) begin
    if (!rst && (m0_rsp_valid || m1_rsp_valid)) begin
      exp_t e;
      chk("rsp_onehot", 32'(m0_rsp_valid && m1_rsp_valid), 32'd0);
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rsp: got m0=%0b m1=%0b expected none",
                 m0_rsp_valid, m1_rsp_valid);
      end else begin
        e = sb.pop_front();
        chk("rsp_idx", 32'(m1_rsp_valid), 32'(e.mst));
        chk("rsp_err", 32'(e.mst ? m1_rsp_err : m0_rsp_err), 32'(e.err));
        chk("rsp_data", e.mst ? m1_rd_data : m0_rd_data, e.data);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end expected $finish");
    $fatal(1);
  end

  initial begin
    vec_t a, b, r;
    int k;
    bit seen;

    //          mst  wr  addr wdata         biten         rdata         d   err wrong
    vecs[0] = '{1'b0,1'b0,3'd3,32'h0,        32'h0,        32'hDEADBEEF, 0,  1'b0,1'b0};
    vecs[1] = '{1'b1,1'b1,3'd4,32'h12345678, 32'h0000FFFF, 32'h0,        5,  1'b0,1'b0};
    vecs[2] = '{1'b0,1'b1,3'd7,32'hCAFEF00D, 32'hFFFFFFFF, 32'h0,        1,  1'b1,1'b0};
    vecs[3] = '{1'b1,1'b0,3'd1,32'h0,        32'h0,        32'hA5A55A5A, 2,  1'b1,1'b0};
    vecs[4] = '{1'b0,1'b0,3'd2,32'h0,        32'h0,        32'h0BADF00D, 3,  1'b0,1'b1};
    vecs[5] = '{1'b1,1'b1,3'd0,32'h55AA55AA, 32'hFF00FF00, 32'h0,        0,  1'b0,1'b1};
    vecs[6] = '{1'b0,1'b0,3'd6,32'h0,        32'h0,        32'h01234567, 14, 1'b0,1'b0};
    vecs[7] = '{1'b1,1'b0,3'd5,32'h0,        32'h0,        32'h89ABCDEF, 15, 1'b0,1'b0};

    m0_req = 0; m0_req_is_wr = 0; m0_addr = '0; m0_wr_data = '0; m0_wr_biten = '0;
    m1_req = 0; m1_req_is_wr = 0; m1_addr = '0; m1_wr_data = '0; m1_wr_biten = '0;
    t_req = 0;
    clr_ack();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_cpuif_req", 32'(cpuif_req), 32'd0);
    chk("rst_cpuif_wr", 32'(cpuif_req_is_wr), 32'd0);
    chk("rst_cpuif_addr", 32'(cpuif_addr), 32'd0);
    chk("rst_cpuif_wdata", cpuif_wr_data, 32'd0);
    chk("rst_cpuif_biten", cpuif_wr_biten, 32'd0);
    chk("rst_rv", 32'({m0_rsp_valid, m1_rsp_valid}), 32'd0);
    chk("rst_err", 32'({m0_rsp_err, m1_rsp_err}), 32'd0);
    chk("rst_rdata", m0_rd_data | m1_rd_data, 32'd0);
    chk("rst_stall", 32'({m0_stall, m1_stall}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc();

    // tie after reset: m0 first, then m1; second tie goes to m0
    a = vecs[0]; a.addr = 3'd1; a.rdata = 32'h11111111;
    b = vecs[3]; b.addr = 3'd6; b.rdata = 32'h22222222; b.err = 1'b0; b.d = 1;
    set_req(1'b0, 1'b1, a);
    set_req(1'b1, 1'b1, b);
    #1;
    chk("tie1_m0_stall", 32'(m0_stall), 32'd0);
    chk("tie1_m1_stall", 32'(m1_stall), 32'd1);
    push_exp(a);
    finish_txn(a);
    chk("tie1_m1_turn", 32'(m1_stall), 32'd0);
    push_exp(b);
    finish_txn(b);
    set_req(1'b0, 1'b1, a);
    set_req(1'b1, 1'b1, b);
    #1;
    chk("tie2_m0_stall", 32'(m0_stall), 32'd0);
    chk("tie2_m1_stall", 32'(m1_stall), 32'd1);
    push_exp(a);
    finish_txn(a);
    chk("tie2_m1_turn", 32'(m1_stall), 32'd0);
    push_exp(b);
    finish_txn(b);

    // stray acks while idle must not start anything
    for (int i = 0; i < 3; i++) begin
      rd_ack = 1'b1; rd_err = 1'b1; rd_data = 32'hFFFF0000;
      wr_ack = 1'b1; wr_err = 1'b1;
      cyc();
      chk("stray_no_req", 32'(cpuif_req), 32'd0);
    end
    clr_ack();
    cyc();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // timeout on the short-timeout instance, then a late ack
    m0_req_is_wr = 1'b0;
    m0_addr = 3'd5;
    t_req = 1'b1;
    #1;
    chk("to_accept", 32'(t_stall0), 32'd0);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 20) begin
      k++;
      cyc();
      if (k == 1) begin
        chk("to_issue", 32'(t_creq), 32'd1);
        chk("to_addr", 32'(t_caddr), 32'd5);
        t_req = 1'b0;
      end
      if (t_rv0) begin
        seen = 1'b1;
        chk("to_latency", 32'(k), 32'd4);
        chk("to_err", 32'(t_re0), 32'd1);
        chk("to_rdata", t_rd0, 32'd0);
        rd_ack = 1'b1; rd_data = 32'hCAFE0001;
      end
    end
    chk("to_seen", 32'(seen), 32'd1);
    cyc();
    chk("to_late_rv", 32'(t_rv0), 32'd0);
    chk("to_late_req", 32'(t_creq), 32'd0);
    cyc();
    chk("to_late_rv2", 32'(t_rv0), 32'd0);
    clr_ack();
    cyc();

    // reset while in WAIT drops the access silently
    r = vecs[3]; r.addr = 3'd2; r.d = 255;
    set_req(1'b1, 1'b1, r);
    #1;
    cyc();
    set_req(1'b1, 1'b0, r);
    cyc();
    cyc();
    chk("pre_rst_addr", 32'(cpuif_addr), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_req", 32'(cpuif_req), 32'd0);
    chk("mid_rst_addr", 32'(cpuif_addr), 32'd0);
    chk("mid_rst_rv", 32'(m1_rsp_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) cyc();
    run_vec(vecs[1]);
    run_vec(vecs[0]);

    repeat (2) cyc();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
